load_store_unit: RTL
====================

# load_store_unit

Core-side initiator for the shared 64-word instruction/data memory: accepts load/store requests from the datapath over a valid/ready handshake, drives the memory's data-port signals, and returns load data or a fault. Adds byte and halfword access on top of the memory's word-only port, using read-modify-write for sub-word stores. Sits between the execute stage and the memory. The fetch port (`pc`/`inst`) is untouched.

## Interface
- `MEM_BYTES`, 256: size of the addressable data space in bytes. Any address at or above it faults.
- `clk`  in  1  sole clock, rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  unit can accept a request.
- `req_we`  in  1  1 = store, 0 = load.
- `req_size`  in  2  00 byte, 01 half, 10 word, 11 illegal.
- `req_unsigned`  in  1  loads only: zero-extend when 1, sign-extend when 0.
- `req_addr`  in  32  byte address.
- `req_wdata`  in  32  store data, right-aligned.
- `rsp_valid`  out  1  response present.
- `rsp_ready`  in  1  consumer takes the response.
- `rsp_rdata`  out  32  load result. 0 for stores and faults.
- `rsp_fault`  out  1  misaligned, out-of-range or illegal-size request.
- `mem_rd_addr`  out  32  to memory `read_data`. Word-aligned.
- `mem_rd_data`  in  32  from memory `data_out`. Combinational, same cycle.
- `mem_we`  out  1  to memory `write_enable`.
- `mem_wr_addr`  out  32  to memory `add_write`. Word-aligned.
- `mem_wr_data`  out  32  to memory `data_write`.

## Operation
- States: IDLE, ACCESS, WRITE, RESP.
- `req_ready` = (state == IDLE).
- On an accept edge (`req_valid & req_ready`), latch `we`, `size`, `unsigned`, `addr` and `wdata`.
- Fault check at accept. Any of these sends the unit to RESP with `rsp_fault=1` and `rsp_rdata=0`, with no memory access:
  - `size==11`
  - half with `addr[0]!=0`
  - word with `addr[1:0]!=0`
  - `addr >= MEM_BYTES`
- Otherwise the unit goes to ACCESS.
- `mem_rd_addr` and `mem_wr_addr` = {latched `addr[31:2]`, 2'b00} in every state after an accept. They are 0 after reset.
- Byte lane = `addr[1:0]`, little-endian: lane 0 = bits 7:0. Half at `addr[1]`: 0 = bits 15:0, 1 = bits 31:16.
- ACCESS, load: `rsp_rdata` <= extracted lane, sign- or zero-extended to 32 bits. Next state RESP.
- ACCESS, word store: `mem_we=1` and `mem_wr_data=wdata` this cycle. Next state RESP.
- ACCESS, byte/half store: merged <= `mem_rd_data` with the selected lane replaced by `wdata[7:0]` / `wdata[15:0]`. Next state WRITE.
- WRITE: `mem_we=1` and `mem_wr_data=merged` for exactly one cycle. Next state RESP.
- RESP: `rsp_valid=1`. `rsp_rdata` and `rsp_fault` are held stable. When `rsp_ready` is high, go to IDLE and clear `rsp_valid`.
- `mem_we` is decoded from state only. It is never high in IDLE or RESP.

## Timing
- Let E0 be the accept edge.
- Load and word store: `rsp_valid` rises after E1.
- Word store: `mem_we` high between E0 and E1. Memory commits at E1.
- Byte/half store: read during ACCESS, `mem_we` high between E1 and E2, commit at E2, `rsp_valid` after E2.
- Fault: `rsp_valid` after E0.
- Back-to-back: with `rsp_ready` held high, the next request is accepted on the edge after RESP exits. Minimum spacing: 3 cycles for loads and word stores, 4 for byte/half stores, 2 for faults.
- No request is accepted while `rsp_valid=1`. `req_*` inputs outside an accept edge are ignored.
- Reset values: state IDLE, `req_ready=1`, `rsp_valid=0`, `rsp_rdata=0`, `rsp_fault=0`, `mem_we=0`, `mem_wr_data=0`, address outputs 0, merged=0.
- Reset is asynchronous. Asserting it mid-operation aborts immediately: `mem_we` falls without waiting for a clock edge, no write commits, and any pending response is discarded.

## Structure
- Package `lsu_pkg` holds:
  - size encodings `SIZE_B`, `SIZE_H`, `SIZE_W`
  - state enum `lsu_state_t`
  - default `MEM_BYTES`
- Sub-module `lsu_lane_align` (purely combinational) provides:
  - extract + extend: (word, `addr[1:0]`, size, unsigned) -> 32-bit result
  - merge: (word, `wdata`, `addr[1:0]`, size) -> merged word
- The top level holds the FSM and all registers.

## Test plan
- Bench connects the unit to the shared memory, driving the memory's reset with `~rst_n`.
- Word store `addr=0x10`, `wdata=0xDEADBEEF` -> `mem_we` high for one cycle with `mem_wr_addr=0x10`; `rsp_valid` one cycle later with `rsp_fault=0`. Word load `0x10` -> `rsp_rdata=0xDEADBEEF`.
- With word `0xDEADBEEF` at `0x10`:
  - signed byte load `0x13` -> `0xFFFFFFDE`
  - unsigned byte load `0x13` -> `0x000000DE`
  - signed half load `0x12` -> `0xFFFFDEAD`
  - unsigned half load `0x10` -> `0x0000BEEF`
- Byte store `addr=0x11`, `wdata=0x123456AA` over `0xDEADBEEF` -> `mem_we` asserted only in the second cycle after accept; word at `0x10` becomes `0xDEADAAEF`.
- Faults, each giving `rsp_fault=1`, `rsp_rdata=0`, `mem_we` never asserted, and `rsp_valid` one cycle after accept:
  - half load `0x03`
  - word store `0x102`
  - word load `0x100`
  - `size=11`
- `rsp_ready` low for 3 cycles during a load response -> `rsp_valid`, `rsp_rdata` and `rsp_fault` stable, `req_ready=0`, and a concurrent `req_valid` is not accepted until after the handshake.
- `rst_n` driven low mid-cycle in WRITE of a byte store -> `mem_we` drops before the next edge, target word unchanged, all outputs at reset values, and the first request after release completes normally.

Source files
------------

// File: rtl/lsu_pkg.sv
// Shared types and constants for the load/store unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package lsu_pkg;

  // Access size encodings carried on req_size.
  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;
  localparam logic [1:0] SIZE_X = 2'b11;

  // Byte size of the data space behind the memory's data port.
  localparam int unsigned DEFAULT_MEM_BYTES = 256;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_WRITE  = 2'd2,
    ST_RESP   = 2'd3
  } lsu_state_t;

  // Request fields captured on the accept edge.
  typedef struct packed {
    logic        we;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] addr;
    logic [31:0] wdata;
  } lsu_req_t;

  // A request faults when it is out of range, misaligned for its size,
  // or uses the reserved size encoding.
  function automatic logic access_fault(input logic [1:0]  size,
                                        input logic [31:0] addr,
                                        input logic [31:0] limit);
    logic f;
    f = (addr >= limit);
    case (size)
      SIZE_B:  f = f;
      SIZE_H:  f = f | addr[0];
      SIZE_W:  f = f | (|addr[1:0]);
      default: f = 1'b1;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/lsu_lane_align.sv
// Byte/half lane extraction with sign/zero extension, and sub-word merge for stores.
// Latency: purely combinational, zero cycles.
// Backpressure: none; outputs follow inputs.
module lsu_lane_align
  import lsu_pkg::*;
(
  input  logic [31:0] word,
  input  logic [31:0] wdata,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        is_unsigned,
  output logic [31:0] ext_data,
  output logic [31:0] merged
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Pick the addressed byte and halfword out of the little-endian word.
  always_comb begin
    byte_sel = word[7:0];
    case (lane)
      2'd0:    byte_sel = word[7:0];
      2'd1:    byte_sel = word[15:8];
      2'd2:    byte_sel = word[23:16];
      default: byte_sel = word[31:24];
    endcase
    half_sel = lane[1] ? word[31:16] : word[15:0];
  end

  // Widen the selected lane to 32 bits; the top bit replicates only for signed loads.
  always_comb begin
    ext_data = word;
    case (size)
      SIZE_B:  ext_data = {{24{~is_unsigned & byte_sel[7]}}, byte_sel};
      SIZE_H:  ext_data = {{16{~is_unsigned & half_sel[15]}}, half_sel};
      default: ext_data = word;
    endcase
  end

  // Replace only the addressed lane of the current word with right-aligned store data.
  always_comb begin
    merged = word;
    case (size)
      SIZE_B: begin
        case (lane)
          2'd0:    merged[7:0]   = wdata[7:0];
          2'd1:    merged[15:8]  = wdata[7:0];
          2'd2:    merged[23:16] = wdata[7:0];
          default: merged[31:24] = wdata[7:0];
        endcase
      end
      SIZE_H: begin
        if (lane[1]) merged[31:16] = wdata[15:0];
        else         merged[15:0]  = wdata[15:0];
      end
      default: merged = wdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store initiator for the shared word memory, adding byte/half access via read-modify-write.
// Latency: response after 1 cycle (fault), 2 (load, word store) or 3 (byte/half store) from accept.
// Backpressure: one request in flight; req_ready stays low until rsp_valid is taken by rsp_ready.
module load_store_unit
  import lsu_pkg::*;
#(
  parameter int unsigned MEM_BYTES = DEFAULT_MEM_BYTES
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_fault,
  output logic [31:0] mem_rd_addr,
  input  logic [31:0] mem_rd_data,
  output logic        mem_we,
  output logic [31:0] mem_wr_addr,
  output logic [31:0] mem_wr_data
);

  lsu_state_t  state, state_nxt;
  lsu_req_t    req_q;
  logic [31:0] merged_q;
  logic [31:0] ext_data;
  logic [31:0] merge_data;
  logic        accept;
  logic        req_fault;
  logic        sub_store;

  assign accept    = req_valid & req_ready;
  assign req_fault = access_fault(req_size, req_addr, 32'(MEM_BYTES));
  assign sub_store = req_q.we & (req_q.size != SIZE_W);

  // The memory port is word-only, so both addresses drop the lane bits.
  assign mem_rd_addr = {req_q.addr[31:2], 2'b00};
  assign mem_wr_addr = {req_q.addr[31:2], 2'b00};

  lsu_lane_align u_align (
    .word        (mem_rd_data),
    .wdata       (req_q.wdata),
    .lane        (req_q.addr[1:0]),
    .size        (req_q.size),
    .is_unsigned (req_q.uns),
    .ext_data    (ext_data),
    .merged      (merge_data)
  );

  // State register; reset drops to IDLE at once so mem_we falls without a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Next state and state-decoded handshake/memory strobes.
  always_comb begin
    state_nxt   = state;
    req_ready   = 1'b0;
    rsp_valid   = 1'b0;
    mem_we      = 1'b0;
    mem_wr_data = '0;
    case (state)
      ST_IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_fault ? ST_RESP : ST_ACCESS;
      end
      ST_ACCESS: begin
        if (sub_store) begin
          state_nxt = ST_WRITE;
        end else begin
          state_nxt = ST_RESP;
          if (req_q.we) begin
            mem_we      = 1'b1;
            mem_wr_data = req_q.wdata;
          end
        end
      end
      ST_WRITE: begin
        mem_we      = 1'b1;
        mem_wr_data = merged_q;
        state_nxt   = ST_RESP;
      end
      ST_RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  // Request capture, load result and merged store word; response fields stay put through RESP.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      req_q     <= '0;
      rsp_rdata <= '0;
      rsp_fault <= 1'b0;
      merged_q  <= '0;
    end else begin
      if (accept) begin
        req_q     <= '{we: req_we, size: req_size, uns: req_unsigned,
                       addr: req_addr, wdata: req_wdata};
        rsp_rdata <= '0;
        rsp_fault <= req_fault;
      end
      if (state == ST_ACCESS) begin
        if (!req_q.we) rsp_rdata <= ext_data;
        else if (sub_store) merged_q <= merge_data;
      end
    end
  end

endmodule
